instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of 10-bit program-buffer entries (power of two, at least 2).
REQ-002 The block SHALL have parameter TIMEOUT, default 4, meaning the maximum STEP pulses per instruction before fault.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port CLKb, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RSTn, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port WR_EN, input, 1 bit: push WR_DATA into the buffer.
REQ-007 The block SHALL have port WR_DATA, input, 10 bits: instruction or operand word.
REQ-008 The block SHALL have port START, input, 1 bit: begin execution from IDLE.
REQ-009 The block SHALL have port EXT, input, 1 bit: processor external-data-enable for the current timestep.
REQ-010 The block SHALL have port DONE, input, 1 bit: processor last-timestep (clear) flag.
REQ-011 The block SHALL have port DATA_OUT, output, 10 bits: word presented to the processor data input.
REQ-012 The block SHALL have port STEP, output, 1 bit: one-cycle processor clock-enable pulse.
REQ-013 The block SHALL have port FULL, output, 1 bit, and port EMPTY, output, 1 bit: buffer status.
REQ-014 The block SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-015 The block SHALL have port ERR, output, 1 bit: sticky timeout fault.

Function
REQ-016 States SHALL be IDLE, FETCH, EXEC, STALL, ERROR, stored as an encoded register.
REQ-017 In IDLE, START=1 with EMPTY=0 SHALL go to FETCH next cycle; START with EMPTY=1 SHALL be ignored.
REQ-018 In FETCH, the block SHALL drive DATA_OUT=head entry and STEP=1, pop one entry, clear the step counter, and go to EXEC.
REQ-019 In EXEC with EXT=0, it SHALL drive STEP=1 and DATA_OUT=0.
REQ-020 In EXEC with EXT=1 and EMPTY=0, it SHALL drive STEP=1 and DATA_OUT=head, and pop that entry.
REQ-021 In EXEC with EXT=1 and EMPTY=1, it SHALL drive STEP=0 and go to STALL.
REQ-022 STALL SHALL hold STEP=0 until EMPTY=0, then return to EXEC.
REQ-023 A STEP issued in EXEC with DONE=1 SHALL end the instruction: go to FETCH if a word remains after any pop this cycle, else IDLE.
REQ-024 The step counter SHALL increment on each STEP in EXEC; reaching TIMEOUT without DONE SHALL go to ERROR with ERR=1.
REQ-025 ERROR SHALL hold STEP=0 and ERR=1 until reset.
REQ-026 A push SHALL be accepted only if FULL=0 at the edge; a push while full SHALL be dropped with no state change.
REQ-027 A simultaneous push and pop SHALL both take effect, with the count unchanged.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; the count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-029 FULL SHALL equal (count==DEPTH) and EMPTY SHALL equal (count==0), both registered-state derived.
REQ-030 STEP SHALL be combinational from state and inputs, never high for two cycles on the same word in FETCH.

Reset
REQ-031 RSTn=0 at an edge SHALL force IDLE, pointers/count/step counter=0, ERR=0, with BUSY=0, STEP=0, DATA_OUT=0, EMPTY=1, FULL=0, including mid-execution.
REQ-032 Buffer contents SHALL NOT require reset.

Configuration
REQ-033 With macro INSTR_SEQUENCER_SINGLE_STEP_EN defined, an extra input STEP_REQ SHALL exist, and FETCH and EXEC SHALL issue STEP only in cycles with STEP_REQ=1, otherwise holding state.
REQ-034 Without INSTR_SEQUENCER_SINGLE_STEP_EN, STEP_REQ SHALL be absent and steps SHALL issue every eligible cycle.

Structure
REQ-035 Shared package bb_pkg SHALL hold WORD_W=10, the sequencer state enum, and the opcode field constants (mode [9:8], function [3:0], LD=4'b0000).
REQ-036 Buffer storage and pointers SHALL be a sub-module named seq_fifo; the FSM and step counter SHALL stay in instr_sequencer.

Verification
REQ-037 Push 0x000 (ld R0), then 0x155, then START; drive EXT=1 on the 2nd STEP with DONE=1 -> DATA_OUT 0x000 then 0x155, two STEPs, IDLE, EMPTY=1.
REQ-038 Push 0x012 (add R1,R0), START; DONE=1 on 4th STEP -> exactly 4 STEP pulses, ERR=0, then IDLE.
REQ-039 Push 0x000 only, START, EXT=1 -> STALL with STEP=0; push 0x2AA -> resumes with DATA_OUT=0x2AA.
REQ-040 Hold DONE=0 -> ERROR after 4 STEPs, ERR=1 sticky; RSTn=0 -> all outputs at reset values.
REQ-041 Push 9 words with DEPTH=8 -> FULL=1 after 8; the 9th is dropped; push and pop in the same cycle while full keep FULL=1; pointer wrap is verified.
REQ-042 With INSTR_SEQUENCER_SINGLE_STEP_EN defined, STEP_REQ is pulsed every 3rd cycle -> STEP follows only those cycles.

Source files
------------

// File: rtl/bb_pkg.sv
// Shared definitions for the instruction sequencer: word width, sequencer
// state encoding and the opcode field positions of a program word.
package bb_pkg;

  localparam int WORD_W = 10;

  // Opcode fields of a 10-bit program word.
  localparam int MODE_HI = 9;
  localparam int MODE_LO = 8;
  localparam int FUNC_HI = 3;
  localparam int FUNC_LO = 0;
  localparam logic [3:0] FN_LD = 4'b0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_STALL = 3'd3,
    S_ERROR = 3'd4
  } seq_state_t;

  function automatic logic [1:0] word_mode(input logic [WORD_W-1:0] w);
    return w[MODE_HI:MODE_LO];
  endfunction

  function automatic logic [3:0] word_func(input logic [WORD_W-1:0] w);
    return w[FUNC_HI:FUNC_LO];
  endfunction

endpackage

// File: rtl/seq_fifo.sv
// Program buffer for the instruction sequencer: DEPTH x WORD_W circular
// buffer with registered pointers and occupancy count. Storage itself is
// not reset; only pointers and count are.
module seq_fifo
  import bb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [WORD_W-1:0] o_rdata,
  output logic [CW-1:0]     o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_rptr;
  logic [AW-1:0]     r_wptr;
  logic [CW-1:0]     r_count;
  logic              w_pop_ok;
  logic              w_push_ok;

  // A pop needs a word present. A push needs a free slot, except that a
  // push landing together with a pop reuses the slot being freed, so a full
  // buffer stays full and the count is unchanged.
  assign w_pop_ok  = i_pop && (r_count != '0);
  assign w_push_ok = i_push && ((r_count != CW'(DEPTH)) || w_pop_ok);

  // Storage write; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  // Pointer and count update; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers program words and feeds them to a
// processor one timestep at a time, issuing a one-cycle STEP enable.
// Optional macro INSTR_SEQUENCER_SINGLE_STEP_EN adds input STEP_REQ; when
// defined, FETCH/EXEC issue STEP only in cycles where STEP_REQ=1.
//
// Handshake: a write is WR_EN (valid) against !FULL (ready); a word is
// taken when WR_EN=1 at a rising edge and FULL=0, or when the buffer is
// being popped in the same cycle. Writes offered while full otherwise are
// dropped. A STEP pulse is the consume strobe for the word on DATA_OUT.
module instr_sequencer
  import bb_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic              CLKb,
  input  logic              RSTn,
  input  logic              WR_EN,
  input  logic [WORD_W-1:0] WR_DATA,
  input  logic              START,
  input  logic              EXT,
  input  logic              DONE,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  input  logic              STEP_REQ,
`endif
  output logic [WORD_W-1:0] DATA_OUT,
  output logic              STEP,
  output logic              FULL,
  output logic              EMPTY,
  output logic              BUSY,
  output logic              ERR,
  output seq_state_t        DBG_STATE
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int SCW = $clog2(TIMEOUT + 1);
  // The step counter tracks EXEC steps only; the FETCH step is the first
  // of the instruction, so an undone EXEC step taken with the counter at
  // TIMEOUT-2 is the TIMEOUT-th step overall and faults.
  localparam logic [SCW-1:0] STEP_LIMIT = SCW'(TIMEOUT - 2);

  seq_state_t        r_state;
  logic [SCW-1:0]    r_step_cnt;
  logic              r_err;

  logic [WORD_W-1:0] w_head;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_go;
  logic              w_step;
  logic              w_pop;
  logic [WORD_W-1:0] w_data;
  logic              w_remain;

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  assign w_go = STEP_REQ;
`else
  assign w_go = 1'b1;
`endif

  seq_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .i_clk   (CLKb),
    .i_rst_n (RSTn),
    .i_push  (WR_EN),
    .i_wdata (WR_DATA),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Word left in the buffer once this cycle's pop (if any) is taken.
  assign w_remain = (w_count > {{(CW-1){1'b0}}, w_pop});

  // Step, pop and data-out decode from the current state and inputs.
  always_comb begin
    w_step = 1'b0;
    w_pop  = 1'b0;
    w_data = '0;
    case (r_state)
      S_FETCH: begin
        w_step = w_go;
        w_pop  = w_go;
        w_data = w_head;
      end
      S_EXEC: begin
        if (!(EXT && w_empty)) begin
          w_step = w_go;
          w_pop  = w_go && EXT;
          if (EXT) w_data = w_head;
        end
      end
      default: begin
        w_step = 1'b0;
      end
    endcase
  end

  // Sequencer FSM, step counter and sticky fault flag.
  always_ff @(posedge CLKb) begin
    if (!RSTn) begin
      r_state    <= S_IDLE;
      r_step_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START && !w_empty) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (w_go) begin
            r_step_cnt <= '0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (EXT && w_empty) begin
            r_state <= S_STALL;
          end else if (w_go) begin
            if (DONE) begin
              r_state <= w_remain ? S_FETCH : S_IDLE;
            end else if (r_step_cnt == STEP_LIMIT) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_step_cnt <= r_step_cnt + SCW'(1);
            end
          end
        end
        S_STALL: begin
          if (!w_empty) r_state <= S_EXEC;
        end
        S_ERROR: begin
          r_err <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign DATA_OUT  = w_data;
  assign STEP      = w_step;
  assign FULL      = w_full;
  assign EMPTY     = w_empty;
  assign BUSY      = (r_state != S_IDLE);
  assign ERR       = r_err;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer (DEPTH=8, TIMEOUT=4).
module tb_instr_sequencer;
  import bb_pkg::*;

  logic              CLKb;
  logic              RSTn;
  logic              WR_EN;
  logic [WORD_W-1:0] WR_DATA;
  logic              START;
  logic              EXT;
  logic              DONE;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  logic              STEP_REQ;
`endif
  logic [WORD_W-1:0] DATA_OUT;
  logic              STEP;
  logic              FULL;
  logic              EMPTY;
  logic              BUSY;
  logic              ERR;
  seq_state_t        dbg_state;

  int n_chk = 0;
  int n_bad = 0;
  logic [WORD_W-1:0] exp_q[$];

  instr_sequencer #(.DEPTH(8), .TIMEOUT(4)) dut (
    .CLKb      (CLKb),
    .RSTn      (RSTn),
    .WR_EN     (WR_EN),
    .WR_DATA   (WR_DATA),
    .START     (START),
    .EXT       (EXT),
    .DONE      (DONE),
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    .STEP_REQ  (STEP_REQ),
`endif
    .DATA_OUT  (DATA_OUT),
    .STEP      (STEP),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .BUSY      (BUSY),
    .ERR       (ERR),
    .DBG_STATE (dbg_state)
  );

  // Clock
  initial CLKb = 1'b0;
  always #5 CLKb = ~CLKb;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLKb);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [WORD_W-1:0] w);
    WR_EN   = 1'b1;
    WR_DATA = w;
    cyc();
    WR_EN   = 1'b0;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    cyc();
    RSTn = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  BUSY, 0);
    chk({tag, "_step"},  STEP, 0);
    chk({tag, "_data"},  DATA_OUT, 0);
    chk({tag, "_empty"}, EMPTY, 1);
    chk({tag, "_full"},  FULL, 0);
    chk({tag, "_err"},   ERR, 0);
    chk({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  initial begin
    int n;
    logic found;
    logic [WORD_W-1:0] exp_w;

    RSTn    = 1'b0;
    WR_EN   = 1'b0;
    WR_DATA = '0;
    START   = 1'b0;
    EXT     = 1'b0;
    DONE    = 1'b0;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    STEP_REQ = 1'b0;
`endif
    cyc();
    cyc();
    RSTn = 1'b1;
    settle();
    chk_reset_outputs("rst0");

    // ld R0 then one external operand, DONE on the second step
    push(10'h000);
    push(10'h155);
    chk("t1_empty_loaded", EMPTY, 0);
    START = 1'b1;
    cyc();
    START = 1'b0;
    settle();
    chk("t1_fetch_state", dbg_state, S_FETCH);
    chk("t1_fetch_step", STEP, 1);
    chk("t1_fetch_data", DATA_OUT, 10'h000);
    chk("t1_fetch_busy", BUSY, 1);
    cyc();
    EXT  = 1'b1;
    DONE = 1'b1;
    settle();
    chk("t1_exec_step", STEP, 1);
    chk("t1_exec_data", DATA_OUT, 10'h155);
    cyc();
    EXT  = 1'b0;
    DONE = 1'b0;
    settle();
    chk("t1_end_busy", BUSY, 0);
    chk("t1_end_empty", EMPTY, 1);
    chk("t1_end_step", STEP, 0);

    // add R1,R0 with DONE on the fourth step
    push(10'h012);
    START = 1'b1;
    cyc();
    START = 1'b0;
    settle();
    chk("t2_fetch_data", DATA_OUT, 10'h012);
    n = 0;
    for (int i = 0; i < 10 && BUSY; i++) begin
      DONE = (n == 3);
      settle();
      if (STEP) n++;
      cyc();
    end
    DONE = 1'b0;
    settle();
    chk("t2_step_count", n, 4);
    chk("t2_err", ERR, 0);
    chk("t2_busy", BUSY, 0);

    // external data request with an empty buffer stalls, then resumes
    push(10'h000);
    START = 1'b1;
    cyc();
    START = 1'b0;
    settle();
    chk("t3_fetch_step", STEP, 1);
    cyc();
    EXT = 1'b1;
    settle();
    chk("t3_exec_empty_step", STEP, 0);
    cyc();
    settle();
    chk("t3_stall_state", dbg_state, S_STALL);
    chk("t3_stall_step", STEP, 0);
    WR_EN   = 1'b1;
    WR_DATA = 10'h2AA;
    cyc();
    WR_EN = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      if (STEP) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("t3_resume_step", found, 1);
    chk("t3_resume_data", DATA_OUT, 10'h2AA);
    DONE = 1'b1;
    cyc();
    DONE = 1'b0;
    EXT  = 1'b0;
    settle();
    chk("t3_end_busy", BUSY, 0);

    // DONE never comes: fault after four steps, sticky until reset
    push(10'h012);
    START = 1'b1;
    cyc();
    START = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (dbg_state == S_ERROR) break;
      if (STEP) n++;
      cyc();
    end
    chk("t4_step_count", n, 4);
    chk("t4_state", dbg_state, S_ERROR);
    chk("t4_err", ERR, 1);
    chk("t4_step", STEP, 0);
    chk("t4_busy", BUSY, 1);
    repeat (3) cyc();
    chk("t4_err_sticky", ERR, 1);
    push(10'h003);
    chk("t4_loaded", EMPTY, 0);
    do_reset();
    settle();
    chk_reset_outputs("t4_rst");

    // fill past DEPTH, push+pop while full, drain through pointer wrap
    for (int i = 0; i < 9; i++) begin
      push(10'h100 + 10'(i));
      if (i < 8) exp_q.push_back(10'h100 + 10'(i));
      if (i == 6) chk("t5_not_full_7", FULL, 0);
      if (i == 7) chk("t5_full_8", FULL, 1);
    end
    chk("t5_full_9", FULL, 1);
    START = 1'b1;
    cyc();
    START = 1'b0;
    EXT     = 1'b1;
    DONE    = 1'b1;
    WR_EN   = 1'b1;
    WR_DATA = 10'h1FF;
    settle();
    chk("t5_fetch_step", STEP, 1);
    exp_w = exp_q.pop_front();
    chk("t5_fetch_data", DATA_OUT, exp_w);
    exp_q.push_back(10'h1FF);
    cyc();
    WR_EN = 1'b0;
    settle();
    chk("t5_full_pushpop", FULL, 1);
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("t5_drain_step", STEP, 1);
      exp_w = exp_q.pop_front();
      chk("t5_drain_data", DATA_OUT, exp_w);
      cyc();
    end
    EXT = 1'b0;
    settle();
    chk("t5_last_step", STEP, 1);
    chk("t5_last_data", DATA_OUT, 0);
    cyc();
    DONE = 1'b0;
    settle();
    chk("t5_end_busy", BUSY, 0);
    chk("t5_end_empty", EMPTY, 1);
    chk("t5_queue_drained", exp_q.size(), 0);

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    // STEP_REQ every third cycle gates every step
    do_reset();
    push(10'h012);
    START = 1'b1;
    cyc();
    START = 1'b0;
    for (int i = 0; i < 9; i++) begin
      STEP_REQ = ((i % 3) == 0);
      settle();
      chk("t6_step_gated", STEP, ((i % 3) == 0));
      cyc();
    end
    STEP_REQ = 1'b0;
    settle();
    chk("t6_err", ERR, 0);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
